// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and the default slave address.
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_prev;
  logic       sda_prev;

  // Idle bus is high, so everything resets to 1 to avoid false edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_ff   <= 2'b11;
      sda_ff   <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_ff   <= {scl_ff[0], scl_raw};
      sda_ff   <= {sda_ff[0], sda_raw};
      scl_prev <= scl_ff[1];
      sda_prev <= sda_ff[1];
    end
  end

  assign sda      = sda_ff[1];
  assign scl_rise = scl_ff[1] & ~scl_prev;
  assign scl_fall = ~scl_ff[1] & scl_prev;
  assign start    = scl_ff[1] & scl_prev & sda_prev & ~sda_ff[1];
  assign stop     = scl_ff[1] & scl_prev & ~sda_prev & sda_ff[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with byte write path; read path compiled in with I2C_SLAVE_READ_EN.
// Handshake: rx_valid / tx_req are single-cycle pulses; tx_data is sampled in the cycle tx_req is raised.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_s,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output i2c_state_e state_dbg
);

  logic scl_rise, scl_fall, sda_s, bus_start, bus_stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_raw  (scl_s),
    .sda_raw  (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda      (sda_s),
    .start    (bus_start),
    .stop     (bus_stop)
  );

  i2c_state_e state;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       ack_phase;
  logic       addr_match;

`ifdef I2C_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
  logic       rw;
  logic       m_nack;
  logic [7:0] tx_shift;
`else
  localparam bit READ_EN = 1'b0;
  logic unused_tx;
  assign unused_tx = ^tx_data;
  assign tx_req    = 1'b0;
`endif

  // shift holds the 7 address bits when the R/W bit arrives.
  assign addr_match = (shift == SLAVE_ADDR) && (READ_EN || !sda_s);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      rw        <= 1'b0;
      m_nack    <= 1'b0;
      tx_shift  <= '0;
      tx_req    <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      tx_req   <= 1'b0;
`endif
      if (bus_stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (bus_start) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shift   <= {shift[5:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr_match) begin
                state     <= ST_ADDR_ACK;
                busy      <= 1'b1;
                ack_phase <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
                rw        <= sda_s;
`endif
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          // First fall drives ACK, second fall ends the ACK bit.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
`ifdef I2C_SLAVE_READ_EN
              if (rw) begin
                state    <= ST_RD_DATA;
                tx_req   <= 1'b1;
                tx_shift <= tx_data;
                sda_oe   <= ~tx_data[7];
              end else begin
                state  <= ST_WR_DATA;
                sda_oe <= 1'b0;
              end
`else
              state  <= ST_WR_DATA;
              sda_oe <= 1'b0;
`endif
            end
          end
          ST_WR_DATA: if (scl_rise) begin
            shift   <= {shift[5:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data   <= {shift, sda_s};
              rx_valid  <= 1'b1;
              state     <= ST_WR_ACK;
              ack_phase <= 1'b0;
            end
          end
          ST_WR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              sda_oe    <= 1'b0;
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              state     <= ST_WR_DATA;
            end
          end
`ifdef I2C_SLAVE_READ_EN
          ST_RD_DATA: if (scl_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              sda_oe <= 1'b0;
              state  <= ST_RD_ACK;
            end else begin
              sda_oe   <= ~tx_shift[6];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              m_nack <= sda_s;
            end else if (scl_fall) begin
              bit_cnt <= '0;
              if (m_nack) begin
                state <= ST_WAIT_STOP;
                busy  <= 1'b0;
              end else begin
                state    <= ST_RD_DATA;
                tx_req   <= 1'b1;
                tx_shift <= tx_data;
                sda_oe   <= ~tx_data[7];
              end
            end
          end
`endif
          ST_IDLE, ST_WAIT_STOP: ;
          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level I2C master tasks, transaction-level reference model, rx scoreboard.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam logic [6:0] ADDR = 7'h50;
`ifdef I2C_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  i2c_state_e state_dbg;

  assign sda_in = sda_m & ~sda_oe;

  // clock / reset
  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_s     (scl),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int rx_cnt = 0;
  int tx_req_cnt = 0;
  int exp_rx = 0;
  int exp_tx = 0;
  bit oe_seen = 1'b0;
  bit busy_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: which address bytes get ACKed
  function automatic bit model_ack(input logic [6:0] a, input bit rw);
    return (a == ADDR) && (!rw || READ_EN);
  endfunction

  // scoreboard / monitors
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (tx_req) tx_req_cnt++;
    if (rx_valid) begin
      rx_cnt++;
      check("rx_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("rx_data_sb", rx_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic qwait();
    repeat (Q) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qwait();
    scl = 1'b1;   qwait();
    sda_m = 1'b0; qwait();
    scl = 1'b0;   qwait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qwait();
    scl = 1'b1;   qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; qwait();
    scl = 1'b1; qwait(); qwait();
    scl = 1'b0; qwait();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qwait();
    scl = 1'b1;   qwait();
    b = sda_in;   qwait();
    scl = 1'b0;   qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    ack = (a == 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] b, input bit master_ack, input logic [7:0] next_tx);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    tx_data = next_tx;
    write_bit(master_ack ? 1'b0 : 1'b1);
  endtask

  initial begin
    bit ack;
    logic v;
    logic [7:0] b;
    logic [7:0] d[4];
    logic [6:0] a;
    bit rw;
    int n;
    int base_rx;
    int base_tx;

    rst = 1'b0; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    repeat (5) @(posedge clk); #1;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b1;
    qwait();

    // addressed write of one byte
    base_rx = rx_cnt;
    exp_q.push_back(8'h5A); exp_rx++;
    bus_start();
    write_byte(8'hA0, ack);
    check("w1_addr_ack", ack, model_ack(7'h50, 1'b0));
    write_byte(8'h5A, ack);
    check("w1_data_ack", ack, 1'b1);
    @(negedge clk);
    check("w1_busy_mid", busy, 1'b1);
    bus_stop();
    @(negedge clk);
    check("w1_busy_after", busy, 1'b0);
    check("w1_rx_data", rx_data, 8'h5A);
    check("w1_rx_pulses", rx_cnt - base_rx, 1);

    // wrong address is ignored
    base_rx = rx_cnt;
    oe_seen = 1'b0; busy_seen = 1'b0;
    bus_start();
    write_byte(8'hA2, ack);
    bus_stop();
    @(negedge clk);
    check("miss_ack", ack, model_ack(7'h51, 1'b0));
    check("miss_oe_seen", oe_seen, 1'b0);
    check("miss_busy_seen", busy_seen, 1'b0);
    check("miss_rx_pulses", rx_cnt - base_rx, 0);

    // read of two bytes
    base_tx = tx_req_cnt;
    tx_data = 8'hC3;
    bus_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", ack, model_ack(7'h50, 1'b1));
`ifdef I2C_SLAVE_READ_EN
    read_byte(b, 1'b1, 8'h3C);
    check("rd_byte0", b, 8'hC3);
    read_byte(b, 1'b0, 8'h00);
    check("rd_byte1", b, 8'h3C);
    exp_tx += 2;
`endif
    bus_stop();
    @(negedge clk);
    check("rd_tx_req_pulses", tx_req_cnt - base_tx, READ_EN ? 2 : 0);
    check("rd_state_idle", state_dbg, ST_IDLE);
    check("rd_busy_after", busy, 1'b0);

    // repeated START between two writes
    base_rx = rx_cnt;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_rx += 2;
    bus_start();
    write_byte(8'hA0, ack);
    check("rs_addr0_ack", ack, 1'b1);
    write_byte(8'h11, ack);
    check("rs_data0_ack", ack, 1'b1);
    bus_start();
    write_byte(8'hA0, ack);
    check("rs_addr1_ack", ack, 1'b1);
    write_byte(8'h22, ack);
    check("rs_data1_ack", ack, 1'b1);
    bus_stop();
    @(negedge clk);
    check("rs_rx_pulses", rx_cnt - base_rx, 2);
    check("rs_rx_data", rx_data, 8'h22);

    // reset in the middle of a read byte
    tx_data = 8'hC3;
    bus_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) read_bit(v);
    @(negedge clk);
`ifdef I2C_SLAVE_READ_EN
    check("mid_oe_before", sda_oe, 1'b1);
    exp_tx += 1;
`endif
    rst = 1'b0;
    #2;
    check("mid_oe_reset", sda_oe, 1'b0);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    oe_seen = 1'b0;
    for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    check("mid_ignored_oe", oe_seen, 1'b0);
    check("mid_ignored_state", state_dbg, ST_IDLE);
    bus_start();
    write_byte(8'hA0, ack);
    check("mid_addr_ack", ack, 1'b1);
    b = 8'($urandom);
    exp_q.push_back(b); exp_rx++;
    write_byte(b, ack);
    check("mid_data_ack", ack, 1'b1);
    bus_stop();

    // randomized transactions against the model
    for (int t = 0; t < 16; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      tx_data = d[0];
      bus_start();
      write_byte({a, rw}, ack);
      check("rnd_addr_ack", ack, model_ack(a, rw));
      if (ack) begin
        if (rw) begin
          for (int i = 0; i < n; i++) begin
            read_byte(b, i < n - 1, d[i + 1]);
            check("rnd_rd_byte", b, d[i]);
          end
          exp_tx += n;
        end else begin
          for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]); exp_rx++;
            write_byte(d[i], ack);
            check("rnd_wr_ack", ack, 1'b1);
          end
        end
      end
      bus_stop();
    end

    qwait();
    check("end_rx_total", rx_cnt, exp_rx);
    check("end_tx_req_total", tx_req_cnt, exp_tx);
    check("end_sb_empty", exp_q.size(), 0);
    check("end_state_idle", state_dbg, ST_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
